// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared widths, the sample type and the seven-segment decoder for the
// single-voice synthesizer.
//   PHASE_W  : phase accumulator width
//   ADDR_W   : sine ROM address width (top phase bits)
//   DATA_W   : signed sample width
//   DIV_W    : frame divider width (CLOCK_50 / 2**DIV_W = sample rate)
// ---------------------------------------------------------------------------
package synth_pkg;

    localparam int PHASE_W = 24;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int DIV_W   = 10;

    // All segments off on an active-low display
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Hex digit to active-low segments, bit6..bit0 = g..a
    function automatic logic [6:0] hexToSeg(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/nco_sine.sv
// ---------------------------------------------------------------------------
// nco_sine
// Phase-accumulator oscillator driving the sine table.
//   CLOCK_50  : system clock
//   Reset     : async active-high, clears phase and address register
//   Clk       : one-cycle sample strobe; phase advances only on it
//   increment : tuning word added to the phase per strobe
//   Phase_out : current phase accumulator value
//   out       : sine sample for the current phase (2 cycles behind phase)
// ---------------------------------------------------------------------------
module nco_sine
    import synth_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic               Clk,
    input  logic [PHASE_W-1:0] increment,
    output logic [PHASE_W-1:0] Phase_out,
    output sample_t            out
);

    logic [PHASE_W-1:0] r_phase;
    logic [ADDR_W-1:0]  r_addr;

    // The accumulator wraps modulo 2**PHASE_W by plain overflow. The tuning
    // word is only looked at on the strobe, so mid-frame changes wait for
    // the next frame.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_phase <= '0;
        end else if (Clk) begin
            r_phase <= r_phase + increment;
        end
    end

    // Only the top phase bits index the table; the low bits carry the
    // fractional part that sets frequency resolution.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_addr <= '0;
        end else begin
            r_addr <= r_phase[PHASE_W-1 -: ADDR_W];
        end
    end

    sine_rom sine (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .addr     (r_addr),
        .data     (out)
    );

    assign Phase_out = r_phase;

endmodule

// File: rtl/sine_rom.sv
// ---------------------------------------------------------------------------
// sine_rom
// 4096 x 16 full-wave sine table with a registered (1-cycle) read.
//   CLOCK_50 : system clock
//   Reset    : async active-high, clears the read data register
//   addr     : table index (one full period spans all addresses)
//   data     : round(32767 * sin(2*pi*addr/4096)), signed
// ---------------------------------------------------------------------------
module sine_rom
    import synth_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] addr,
    output sample_t           data
);

    localparam int  DEPTH = 1 << ADDR_W;
    localparam real PI    = 3.14159265358979323846;

    sample_t w_table [DEPTH];
    sample_t r_data;

    // The table contents are elaboration-time constants; rounding is half
    // away from zero so that the positive and negative lobes are mirror images.
    for (genvar a = 0; a < DEPTH; a++) begin : g_entry
        localparam real SCALED  = 32767.0 * $sin(2.0 * PI * real'(a) / real'(DEPTH));
        localparam int  ROUNDED = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5)
                                                  : -$rtoi(0.5 - SCALED);
        assign w_table[a] = sample_t'(ROUNDED);
    end

    // Synchronous read so the table can map onto block RAM
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_data <= '0;
        end else begin
            r_data <= w_table[addr];
        end
    end

    assign data = r_data;

endmodule

// File: rtl/synth_core.sv
// ---------------------------------------------------------------------------
// synth_core
// Single-voice synthesizer top: frame divider, oscillator, I2S DAC
// serializer and tuning-word display.
//   CLOCK_50    : 50 MHz system clock
//   Reset       : async active-high
//   KEY         : active-low buttons, KEY[0] mutes the output
//   SW          : tuning word (phase increment per frame)
//   AUD_XCK     : codec master clock, CLOCK_50/4
//   AUD_BCLK    : bit clock, CLOCK_50/16
//   AUD_DACLRCK : frame clock, CLOCK_50/1024, 0 = left
//   AUD_ADCLRCK : copy of AUD_DACLRCK
//   AUD_DACDAT  : I2S serial data, MSB one BCLK after the LRCK edge
//   AUD_ADCDAT  : unused
//   I2C_SCLK    : held high, I2C_SDAT released
//   HEX0..HEX7  : active-low seven-segment digits, SW on HEX4..HEX0
// ---------------------------------------------------------------------------
module synth_core
    import synth_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic        AUD_XCK,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_ADCLRCK,
    output logic        AUD_DACDAT,
    input  logic        AUD_ADCDAT,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   w_nextCnt;
    logic               w_strobe;
    logic [4:0]         w_nextSlot;
    logic [3:0]         w_bitIdx;
    logic               w_slotBit;
    sample_t            w_oscOut;
    sample_t            r_sample;
    logic               r_dacdat;
    logic [PHASE_W-1:0] w_unusedPhase;
    logic               w_unused;

    // Free-running divider; every audio clock is a bit of this counter so
    // they stay phase-locked to each other and are all low in reset.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nextCnt;
        end
    end

    assign w_nextCnt   = r_cnt + 1'b1;
    assign w_strobe    = (r_cnt == '1);
    assign AUD_XCK     = r_cnt[1];
    assign AUD_BCLK    = r_cnt[3];
    assign AUD_DACLRCK = r_cnt[DIV_W-1];
    assign AUD_ADCLRCK = r_cnt[DIV_W-1];

    nco_sine osc0 (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .Clk       (w_strobe),
        .increment ({{(PHASE_W-18){1'b0}}, SW}),
        .Phase_out (w_unusedPhase),
        .out       (w_oscOut)
    );

    // Capture one sample per frame at cnt==8, well after the oscillator
    // pipeline has settled on the new phase and before the first data slot.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_sample <= '0;
        end else if (r_cnt == DIV_W'(8)) begin
            r_sample <= KEY[0] ? w_oscOut : '0;
        end
    end

    // The data bit is chosen for the slot that is about to start, so the
    // output register changes together with the BCLK falling edge. Slots
    // 1..16 carry the sample MSB first; every other slot is zero.
    assign w_nextSlot = w_nextCnt[8:4];
    assign w_bitIdx   = 4'(5'd16 - w_nextSlot);
    assign w_slotBit  = (w_nextSlot >= 5'd1 && w_nextSlot <= 5'd16) ? r_sample[w_bitIdx] : 1'b0;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_dacdat <= 1'b0;
        end else if (r_cnt[3:0] == 4'hF) begin
            r_dacdat <= w_slotBit;
        end
    end

    assign AUD_DACDAT = r_dacdat;

    // Codec configuration bus is parked
    assign I2C_SCLK = 1'b1;
    assign I2C_SDAT = 1'bz;

    // Tuning word shown as five hex digits; the top three displays stay dark
    assign HEX0 = hexToSeg(SW[3:0]);
    assign HEX1 = hexToSeg(SW[7:4]);
    assign HEX2 = hexToSeg(SW[11:8]);
    assign HEX3 = hexToSeg(SW[15:12]);
    assign HEX4 = hexToSeg({2'b00, SW[17:16]});
    assign HEX5 = SEG_BLANK;
    assign HEX6 = SEG_BLANK;
    assign HEX7 = SEG_BLANK;

    assign w_unused = ^{KEY[3:1], AUD_ADCDAT, w_unusedPhase};

endmodule

// File: tb/tb_synth_core.sv
// ---------------------------------------------------------------------------
// tb_synth_core
// Self-checking bench for synth_core. A frame-level reference model (phase
// as a running sum of tuning words, sample as a rounded sine, bit stream
// from slot arithmetic) is compared with the DUT every clock cycle.
// ---------------------------------------------------------------------------
module tb_synth_core;

    localparam real PI = 3.14159265358979323846;

    logic        CLOCK_50;
    logic        Reset;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic        AUD_ADCDAT;
    logic        AUD_XCK;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_ADCLRCK;
    logic        AUD_DACDAT;
    logic        I2C_SCLK;
    wire         I2C_SDAT;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: t counts clock cycles since reset release
    int t       = 0;
    int mPhase  = 0;
    int mSample = 0;

    typedef struct {
        logic [17:0] sw;
        logic [55:0] hex;
    } hexVec_t;

    hexVec_t hexTab [5];

    synth_core dut (
        .CLOCK_50    (CLOCK_50),
        .Reset       (Reset),
        .KEY         (KEY),
        .SW          (SW),
        .AUD_XCK     (AUD_XCK),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .I2C_SCLK    (I2C_SCLK),
        .I2C_SDAT    (I2C_SDAT),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5),
        .HEX6        (HEX6),
        .HEX7        (HEX7)
    );

    // 50 MHz clock
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Ideal sine sample, rounded half away from zero
    function automatic int sineRef(input int a);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(a) / 4096.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // One comparison: count it, report it on mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0d: got %h, expected %h", name, t, actual, expected);
        end
    endtask

    // Advance one cycle and compare phase, audio clocks and serial data with
    // the model. Inputs seen at the last rising edge are the current ones.
    task automatic stepCycle();
        int c, k, expBit;
        logic [28:0] expV, actV;
        @(negedge CLOCK_50);
        c = t % 1024;
        if (c == 0) mPhase = (mPhase + int'(SW)) % 16777216;
        if (c == 9) mSample = KEY[0] ? sineRef(mPhase / 4096) : 0;
        k = (c % 512) / 16;
        expBit = (k >= 1 && k <= 16) ? ((mSample >> (16 - k)) & 1) : 0;
        expV = {24'(mPhase), 1'((c / 2) % 2), 1'((c / 8) % 2), 1'(c / 512), 1'(c / 512), 1'(expBit)};
        actV = {dut.osc0.Phase_out, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT};
        checkOutput("cycle", 64'(actV), 64'(expV));
        t++;
    endtask

    // Set inputs, then run and check for the given number of cycles
    task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] key, input int cycles);
        SW  = sw;
        KEY = key;
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    // Release reset just after a falling edge and restart the model
    task automatic releaseReset();
        @(negedge CLOCK_50);
        Reset   = 1'b0;
        t       = 1;
        mPhase  = 0;
        mSample = 0;
    endtask

    // Main sequence
    initial begin
        logic orData;

        hexTab[0] = '{18'h12345, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
        hexTab[1] = '{18'h3ABCD, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}};
        hexTab[2] = '{18'h2EF06, {7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h06, 7'h0E, 7'h40, 7'h02}};
        hexTab[3] = '{18'h00789, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h78, 7'h00, 7'h10}};
        hexTab[4] = '{18'h3FFFF, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};

        Reset      = 1'b0;
        KEY        = 4'hF;
        SW         = '0;
        AUD_ADCDAT = 1'b0;
        #1 Reset = 1'b1;

        // Display decode is combinational and independent of reset
        for (int i = 0; i < 5; i++) begin
            SW = hexTab[i].sw;
            #1;
            checkOutput("hex", 64'({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(hexTab[i].hex));
        end
        SW = '0;

        // Long reset hold: everything cleared, clocks low, SCLK parked high
        #13000;
        checkOutput("reset state",
                    64'({dut.osc0.Phase_out, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT, I2C_SCLK}),
                    64'({24'h0, 5'b0, 1'b1}));
        releaseReset();

        // Zero tuning word: phase and output stay at zero
        applyStimulus(18'd0, 4'hF, 3 * 1024);
        checkOutput("sw0 phase", 64'(dut.osc0.Phase_out), 64'h0);

        // 4096 per frame: one table step per frame
        applyStimulus(18'd4096, 4'hF, 4 * 1024);
        checkOutput("sw4096 phase", 64'(dut.osc0.Phase_out), 64'h004000);

        // Random tuning words and mute, changing mid-frame
        for (int i = 0; i < 12; i++) begin
            applyStimulus(18'($urandom_range(0, 262143)),
                          {3'b111, 1'($urandom_range(0, 3) != 0)},
                          $urandom_range(200, 700));
        end

        // Mute: after one full frame the line must be silent for a frame
        applyStimulus(18'd151182, 4'hE, 1024);
        orData = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            stepCycle();
            orData = orData | AUD_DACDAT;
        end
        checkOutput("mute silent", 64'(orData), 64'h0);
        applyStimulus(18'd151182, 4'hF, 1024);

        // Asynchronous reset asserted between clock edges clears at once
        #5 Reset = 1'b1;
        #1;
        checkOutput("async reset",
                    64'({dut.osc0.Phase_out, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT}),
                    64'h0);
        #200;
        releaseReset();

        // Wrap: 65 frames of the largest tuning word from zero phase
        applyStimulus(18'h3FFFF, 4'hF, 65 * 1024);
        checkOutput("phase wrap", 64'(dut.osc0.Phase_out), 64'((65 * 'h3FFFF) % (1 << 24)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
